// File: rtl/dbi_pkg.sv
// Shared DBI definitions: bus geometry, FIFO occupancy states and the
// reference decode used by both the receiver and the encoder bench.
package dbi_pkg;

  localparam int unsigned DBI_DATA_W   = 8;
  localparam int unsigned DBI_BUS_W    = 9;
  localparam int unsigned DBI_FLAG_BIT = 0;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  function automatic logic [DBI_DATA_W-1:0] dbi_decode(input logic [DBI_BUS_W-1:0] bus);
    return bus[DBI_BUS_W-1:1] ^ {DBI_DATA_W{bus[DBI_FLAG_BIT]}};
  endfunction

endpackage

// File: rtl/dbi_decoder_rx_if.sv
// Link-side and consumer-side valid/ready streams of the DBI receiver.
interface dbi_decoder_rx_if
  import dbi_pkg::*;
#(
  parameter int unsigned DATA_W = DBI_DATA_W
);
  logic [DATA_W:0]   in_v;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] out_u;
  logic              out_inv;
  logic              out_valid;
  logic              out_ready;

  modport slave (
    input  in_v, in_valid, out_ready,
    output in_ready, out_u, out_inv, out_valid
  );

  modport master (
    output in_v, in_valid, out_ready,
    input  in_ready, out_u, out_inv, out_valid
  );
endinterface

// File: rtl/dbi_popcount.sv
// Combinational population count of an N-bit vector.
module dbi_popcount #(
  parameter int unsigned N = 9
) (
  input  logic [N-1:0]             vec_i,
  output logic [$clog2(N+1)-1:0]   cnt_o
);
  localparam int unsigned W = $clog2(N+1);

  always_comb begin
    cnt_o = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cnt_o = cnt_o + W'(vec_i[i]);
    end
  end
endmodule

// File: rtl/dbi_decoder_rx.sv
// DBI-AC receiver: decodes bus words into a 2-entry FIFO and keeps
// saturating link statistics (words, inverted words, bus toggles).
module dbi_decoder_rx
  import dbi_pkg::*;
#(
  parameter int unsigned DATA_W = DBI_DATA_W,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  dbi_decoder_rx_if.slave      link,
  input  logic                 clr_stats,
  output logic [CNT_W-1:0]     word_cnt,
  output logic [CNT_W-1:0]     inv_cnt,
  output logic [CNT_W-1:0]     tog_cnt
);
  localparam int unsigned BUS_W = DATA_W + 1;
  localparam int unsigned PC_W  = $clog2(BUS_W + 1);

  occ_e              occ_q, occ_d;
  logic [BUS_W-1:0]  mem_q [2];
  logic              wr_q, rd_q;
  logic [BUS_W-1:0]  v_prev_q;
  logic [CNT_W-1:0]  word_q, word_d, inv_q, inv_d, tog_q, tog_d;
  logic [DATA_W-1:0] payload;
  logic [PC_W-1:0]   tog_inc;
  logic              push, pop;

  if (DATA_W == DBI_DATA_W) begin : g_pkg_decode
    assign payload = dbi_decode(link.in_v);
  end else begin : g_gen_decode
    assign payload = link.in_v[DATA_W:1] ^ {DATA_W{link.in_v[0]}};
  end

  assign link.in_ready  = (occ_q != OCC_FULL);
  assign link.out_valid = (occ_q != OCC_EMPTY);
  assign link.out_u     = mem_q[rd_q][BUS_W-1:1];
  assign link.out_inv   = mem_q[rd_q][0];

  assign push = link.in_valid && link.in_ready;
  assign pop  = link.out_valid && link.out_ready;

  always_comb begin
    occ_d = occ_q;
    unique case (occ_q)
      OCC_EMPTY: if (push)         occ_d = OCC_ONE;
      OCC_ONE:   if (push && !pop) occ_d = OCC_FULL;
                 else if (!push && pop) occ_d = OCC_EMPTY;
      OCC_FULL:  if (pop)          occ_d = OCC_ONE;
      default:                     occ_d = OCC_EMPTY;
    endcase
  end

  // Pointers move independently; a push+pop at occupancy 1 lands the new
  // word in the slot the read pointer advances to, so the head follows it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q <= OCC_EMPTY;
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      occ_q <= occ_d;
      if (push) begin
        mem_q[wr_q] <= {payload, link.in_v[0]};
        wr_q        <= ~wr_q;
      end
      if (pop) begin
        rd_q <= ~rd_q;
      end
    end
  end

  dbi_popcount #(
    .N (BUS_W)
  ) u_popcount (
    .vec_i (link.in_v ^ v_prev_q),
    .cnt_o (tog_inc)
  );

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [PC_W-1:0]  b);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + (CNT_W+1)'(b);
    return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
  endfunction

  always_comb begin
    word_d = word_q;
    inv_d  = inv_q;
    tog_d  = tog_q;
    if (clr_stats) begin
      word_d = '0;
      inv_d  = '0;
      tog_d  = '0;
    end else if (push) begin
      word_d = sat_add(word_q, PC_W'(1));
      inv_d  = sat_add(inv_q, PC_W'(link.in_v[0]));
      tog_d  = sat_add(tog_q, tog_inc);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q   <= '0;
      inv_q    <= '0;
      tog_q    <= '0;
      v_prev_q <= '0;
    end else begin
      word_q <= word_d;
      inv_q  <= inv_d;
      tog_q  <= tog_d;
      if (push) begin
        v_prev_q <= link.in_v;
      end
    end
  end

  assign word_cnt = word_q;
  assign inv_cnt  = inv_q;
  assign tog_cnt  = tog_q;

endmodule

// File: tb/tb_dbi_decoder_rx.sv
// Directed and random-stream bench for dbi_decoder_rx with a byte scoreboard.
module tb_dbi_decoder_rx;
  logic clk;
  logic rst;
  logic clr_m, clr_s;
  logic [15:0] word_m, inv_m, tog_m;
  logic [3:0]  word_s, inv_s, tog_s;

  dbi_decoder_rx_if #(.DATA_W(8)) m_if ();
  dbi_decoder_rx_if #(.DATA_W(8)) s_if ();

  dbi_decoder_rx #(.DATA_W(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .link(m_if), .clr_stats(clr_m),
    .word_cnt(word_m), .inv_cnt(inv_m), .tog_cnt(tog_m)
  );

  dbi_decoder_rx #(.DATA_W(8), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .link(s_if), .clr_stats(clr_s),
    .word_cnt(word_s), .inv_cnt(inv_s), .tog_cnt(tog_s)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;
  int rcvd  = 0;
  logic [7:0]  cur_byte;
  logic [8:0]  sb_q[$];
  logic [15:0] mdl_word, mdl_inv, mdl_tog;
  logic [8:0]  mdl_prev;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_word(input logic [7:0] b, input logic f);
    cur_byte  = b;
    m_if.in_v = {b ^ {8{f}}, f};
  endtask

  function automatic logic enc_flag(input logic [7:0] b, input logic [8:0] prev);
    int t0, t1;
    t0 = $countones({b, 1'b0} ^ prev);
    t1 = $countones({~b, 1'b1} ^ prev);
    return t1 < t0;
  endfunction

  // Scoreboard and statistics model, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
      mdl_word = '0; mdl_inv = '0; mdl_tog = '0; mdl_prev = '0;
    end else begin
      check("mon_word", 32'(word_m), 32'(mdl_word));
      check("mon_inv",  32'(inv_m),  32'(mdl_inv));
      check("mon_tog",  32'(tog_m),  32'(mdl_tog));
      if (m_if.out_valid && m_if.out_ready) begin
        if (sb_q.size() == 0) begin
          check("sb_underflow", 32'(m_if.out_u), 32'hDEAD);
        end else begin
          logic [8:0] e;
          e = sb_q.pop_front();
          check("sb_out_u",   32'(m_if.out_u),   32'(e[8:1]));
          check("sb_out_inv", 32'(m_if.out_inv), 32'(e[0]));
          rcvd++;
        end
      end
      if (clr_m) begin
        mdl_word = '0; mdl_inv = '0; mdl_tog = '0;
      end
      if (m_if.in_valid && m_if.in_ready) begin
        sb_q.push_back({cur_byte, m_if.in_v[0]});
        if (!clr_m) begin
          mdl_word = mdl_word + 16'd1;
          mdl_inv  = mdl_inv + 16'(m_if.in_v[0]);
          mdl_tog  = mdl_tog + 16'($countones(m_if.in_v ^ mdl_prev));
        end
        mdl_prev = m_if.in_v;
      end
    end
  end

  initial begin
    int sent, cyc;
    logic acc;
    logic [7:0] b;
    logic [8:0] enc_prev;

    rst = 1'b1; clr_m = 1'b0; clr_s = 1'b0;
    m_if.in_v = '0; m_if.in_valid = 1'b0; m_if.out_ready = 1'b0; cur_byte = '0;
    s_if.in_v = '0; s_if.in_valid = 1'b0; s_if.out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("rst_in_ready",  32'(m_if.in_ready),  32'd1);
    check("rst_out_valid", 32'(m_if.out_valid), 32'd0);
    check("rst_out_u",     32'(m_if.out_u),     32'd0);
    check("rst_out_inv",   32'(m_if.out_inv),   32'd0);
    check("rst_word",      32'(word_m),         32'd0);

    // First two directed words
    drive_word(8'h7F, 1'b1); m_if.in_valid = 1'b1; m_if.out_ready = 1'b1;
    check("t1_bus", 32'(m_if.in_v), 32'h101);
    tick();
    check("t1_out_valid", 32'(m_if.out_valid), 32'd1);
    check("t1_out_u",     32'(m_if.out_u),     32'h7F);
    check("t1_out_inv",   32'(m_if.out_inv),   32'd1);
    check("t1_word",      32'(word_m),         32'd1);
    check("t1_inv",       32'(inv_m),          32'd1);
    check("t1_tog",       32'(tog_m),          32'd2);
    drive_word(8'h7F, 1'b0);
    tick();
    m_if.in_valid = 1'b0;
    check("t2_out_u",   32'(m_if.out_u),   32'h7F);
    check("t2_out_inv", 32'(m_if.out_inv), 32'd0);
    check("t2_inv",     32'(inv_m),        32'd1);
    check("t2_tog",     32'(tog_m),        32'd11);
    tick();

    // Backpressure: only two words fit
    m_if.out_ready = 1'b0; m_if.in_valid = 1'b1;
    drive_word(8'hA5, 1'b0); tick();
    drive_word(8'h3C, 1'b1); tick();
    check("bp_in_ready_full", 32'(m_if.in_ready), 32'd0);
    drive_word(8'hE1, 1'b0); tick();
    check("bp_in_ready_held", 32'(m_if.in_ready), 32'd0);
    check("bp_out_u_held",    32'(m_if.out_u),    32'hA5);
    check("bp_word_cnt",      32'(word_m),        32'd4);
    m_if.out_ready = 1'b1;
    cyc = 0;
    while (cyc < 10) begin
      acc = m_if.in_valid && m_if.in_ready;
      tick(); cyc++;
      if (acc) break;
    end
    check("bp_third_accept", 32'(cyc < 10), 32'd1);
    m_if.in_valid = 1'b0;
    cyc = 0;
    while (sb_q.size() != 0 && cyc < 50) begin tick(); cyc++; end
    check("bp_drain", 32'(sb_q.size()), 32'd0);
    check("bp_rcvd",  32'(rcvd), 32'd5);

    // Clear, then 1000 encoder-model words with random handshakes
    clr_m = 1'b1; tick(); clr_m = 1'b0;
    check("clr_word", 32'(word_m), 32'd0);
    check("clr_tog",  32'(tog_m),  32'd0);
    rcvd = 0; sent = 0; cyc = 0;
    enc_prev = m_if.in_v;
    while (sent < 1000 && cyc < 20000) begin
      if (!m_if.in_valid && $urandom_range(0, 9) < 7) begin
        b = 8'($urandom_range(0, 255));
        drive_word(b, enc_flag(b, enc_prev));
        enc_prev = m_if.in_v;
        m_if.in_valid = 1'b1;
      end
      m_if.out_ready = ($urandom_range(0, 9) < 7);
      acc = m_if.in_valid && m_if.in_ready;
      tick(); cyc++;
      if (acc) begin sent++; m_if.in_valid = 1'b0; end
    end
    m_if.in_valid = 1'b0; m_if.out_ready = 1'b1;
    cyc = 0;
    while (sb_q.size() != 0 && cyc < 100) begin tick(); cyc++; end
    check("rand_sent",  32'(sent), 32'd1000);
    check("rand_rcvd",  32'(rcvd), 32'd1000);
    check("rand_word",  32'(word_m), 32'd1000);
    check("rand_inv",   32'(inv_m), 32'(mdl_inv));
    check("rand_tog",   32'(tog_m), 32'(mdl_tog));

    // Asynchronous reset with two words buffered
    m_if.out_ready = 1'b0; m_if.in_valid = 1'b1;
    drive_word(8'h11, 1'b0); tick();
    drive_word(8'h22, 1'b1); tick();
    m_if.in_valid = 1'b0;
    check("ar_full", 32'(m_if.in_ready), 32'd0);
    #1 rst = 1'b1;
    #1;
    check("ar_out_valid", 32'(m_if.out_valid), 32'd0);
    check("ar_in_ready",  32'(m_if.in_ready),  32'd1);
    check("ar_word",      32'(word_m),         32'd0);
    check("ar_tog",       32'(tog_m),          32'd0);
    tick();
    rst = 1'b0;
    drive_word(8'h7F, 1'b1); m_if.in_valid = 1'b1; m_if.out_ready = 1'b1;
    tick();
    m_if.in_valid = 1'b0;
    check("ar_post_out_u", 32'(m_if.out_u), 32'h7F);
    check("ar_post_word",  32'(word_m),     32'd1);
    check("ar_post_tog",   32'(tog_m),      32'd2);
    tick(); tick();

    // Saturation with 4-bit counters
    s_if.in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      s_if.in_v = (i % 2 == 1) ? 9'h001 : 9'h1FF;
      tick();
    end
    check("sat_word", 32'(word_s), 32'd15);
    check("sat_inv",  32'(inv_s),  32'd15);
    check("sat_tog",  32'(tog_s),  32'd15);
    s_if.in_v = 9'h1FF; clr_s = 1'b1;
    tick();
    clr_s = 1'b0;
    check("sat_clr_word", 32'(word_s), 32'd0);
    check("sat_clr_inv",  32'(inv_s),  32'd0);
    check("sat_clr_tog",  32'(tog_s),  32'd0);
    tick();
    s_if.in_valid = 1'b0;
    check("sat_after_word", 32'(word_s), 32'd1);
    check("sat_after_inv",  32'(inv_s),  32'd1);
    check("sat_after_tog",  32'(tog_s),  32'd0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
